// File: rtl/shared_mem_arbiter.sv
// shared_mem_arbiter: round-robin arbiter giving core_count cores serialized
// access to one single-port synchronous data memory. Each transaction runs
// IDLE -> ISSUE -> WAIT (mem_latency cycles) -> ACK and ends with a one-hot ack.
// Optional feature macro: SHARED_MEM_WR_PROTECT_EN (suppress writes below protect_limit).
module shared_mem_arbiter #(
    parameter int core_count  = 4,
    parameter int reg_width   = 12,
    parameter int addr_width  = 12,
    parameter int mem_latency = 1,
    parameter logic [addr_width-1:0] protect_limit = addr_width'(64)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [core_count-1:0]            req,
    input  logic [core_count-1:0]            wr,
    input  logic [core_count*addr_width-1:0] addr,
    input  logic [core_count*reg_width-1:0]  wdata,
    output logic [core_count-1:0]            ack,
    output logic [reg_width-1:0]             rdata,
    output logic                             err,
    output logic                             busy,
    output logic [addr_width-1:0]            mem_address,
    output logic [reg_width-1:0]             mem_data,
    output logic                             mem_wren,
    input  logic [reg_width-1:0]             mem_q
);

    localparam int idx_w = (core_count > 1) ? $clog2(core_count) : 1;
    localparam int cnt_w = $clog2(mem_latency + 1);

`ifdef SHARED_MEM_WR_PROTECT_EN
    localparam bit protect_en = 1'b1;
`else
    localparam bit protect_en = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t                  state, next_state;
    logic [idx_w-1:0]        last;
    logic [idx_w-1:0]        ch;
    logic [idx_w-1:0]        grant_idx;
    logic                    grant_valid;
    logic [cnt_w-1:0]        cnt;
    logic                    wr_q;
    logic                    err_q;
    logic                    wr_sel;
    logic                    wr_blocked;
    logic [addr_width-1:0]   addr_sel;
    logic [reg_width-1:0]    wdata_sel;
    int                      cand;

    // Round-robin pick: scan last+1, last+2, ... wrapping; first requester wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 1; k <= core_count; k++) begin
            cand = int'(last) + k;
            if (cand >= core_count) cand = cand - core_count;
            if (!grant_valid && req[idx_w'(cand)]) begin
                grant_valid = 1'b1;
                grant_idx   = idx_w'(cand);
            end
        end
    end

    assign addr_sel   = addr[int'(grant_idx)*addr_width +: addr_width];
    assign wdata_sel  = wdata[int'(grant_idx)*reg_width +: reg_width];
    assign wr_sel     = wr[grant_idx];
    // A protected write still runs the full sequence, it just never reaches memory.
    assign wr_blocked = protect_en && wr_sel && (addr_sel < protect_limit);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_valid) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (cnt == cnt_w'(1)) next_state = ACK;
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: latch the granted request, drive memory, capture read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            last        <= idx_w'(core_count - 1);
            ch          <= '0;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            cnt         <= '0;
            mem_address <= '0;
            mem_data    <= '0;
            mem_wren    <= 1'b0;
            rdata       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        ch          <= grant_idx;
                        wr_q        <= wr_sel;
                        err_q       <= wr_blocked;
                        mem_address <= addr_sel;
                        mem_data    <= wdata_sel;
                        mem_wren    <= wr_sel && !wr_blocked;
                    end
                end
                ISSUE: begin
                    mem_wren <= 1'b0;
                    cnt      <= cnt_w'(mem_latency);
                end
                WAIT: begin
                    cnt <= cnt - cnt_w'(1);
                    if (cnt == cnt_w'(1) && !wr_q) rdata <= mem_q;
                end
                ACK: last <= ch;
                default: ;
            endcase
        end
    end

    // Completion pulse and status decode.
    always_comb begin
        ack = '0;
        if (state == ACK) ack[ch] = 1'b1;
    end

    assign err  = (state == ACK) && err_q;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Scoreboard bench for shared_mem_arbiter: two instances (mem_latency 1 and 3),
// each with its own behavioural memory, expectation queue and ack monitor.
module tb_shared_mem_arbiter;
    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 12;
`ifdef SHARED_MEM_WR_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int             ch;
        bit             is_rd;
        logic [DW-1:0]  rdata;
        bit             err;
        int             cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    // DUT A: mem_latency = 1
    logic [N-1:0]    req_a, wr_a, ack_a;
    logic [N*AW-1:0] addr_a;
    logic [N*DW-1:0] wdata_a;
    logic [DW-1:0]   rdata_a, mem_data_a, mem_q_a;
    logic [AW-1:0]   mem_address_a;
    logic            err_a, busy_a, mem_wren_a;

    // DUT B: mem_latency = 3
    logic [N-1:0]    req_b, wr_b, ack_b;
    logic [N*AW-1:0] addr_b;
    logic [N*DW-1:0] wdata_b;
    logic [DW-1:0]   rdata_b, mem_data_b, mem_q_b;
    logic [AW-1:0]   mem_address_b;
    logic            err_b, busy_b, mem_wren_b;

    shared_mem_arbiter #(.core_count(N), .reg_width(DW), .addr_width(AW), .mem_latency(1)) dut_a (
        .clk(clk), .reset(reset), .req(req_a), .wr(wr_a), .addr(addr_a), .wdata(wdata_a),
        .ack(ack_a), .rdata(rdata_a), .err(err_a), .busy(busy_a),
        .mem_address(mem_address_a), .mem_data(mem_data_a), .mem_wren(mem_wren_a), .mem_q(mem_q_a));

    shared_mem_arbiter #(.core_count(N), .reg_width(DW), .addr_width(AW), .mem_latency(3)) dut_b (
        .clk(clk), .reset(reset), .req(req_b), .wr(wr_b), .addr(addr_b), .wdata(wdata_b),
        .ack(ack_b), .rdata(rdata_b), .err(err_b), .busy(busy_b),
        .mem_address(mem_address_b), .mem_data(mem_data_b), .mem_wren(mem_wren_b), .mem_q(mem_q_b));

    // Memory models: preload on the first edge, then synchronous read/write.
    logic [DW-1:0] mem_a [0:(1<<AW)-1];
    logic [DW-1:0] mem_b [0:(1<<AW)-1];
    logic [DW-1:0] qb1, qb2, qb3;

    always @(posedge clk) begin
        if (cyc == 0) begin
            mem_a[12'h0A5] <= 12'h3C7;
            mem_a[12'h200] <= 12'h111;
            mem_a[12'h201] <= 12'h222;
            mem_a[12'h100] <= 12'h000;
            mem_a[12'h020] <= 12'h000;
            mem_a[12'h040] <= 12'h000;
            mem_b[12'h010] <= 12'h7FF;
            mem_q_a <= '0;
            qb1 <= '0; qb2 <= '0; qb3 <= '0;
        end else begin
            if (mem_wren_a) mem_a[mem_address_a] <= mem_data_a;
            mem_q_a <= mem_a[mem_address_a];
            if (mem_wren_b) mem_b[mem_address_b] <= mem_data_b;
            qb1 <= mem_b[mem_address_b];
            qb2 <= qb1;
            qb3 <= qb2;
        end
    end
    assign mem_q_b = qb3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input int ch, input bit rd, input logic [DW-1:0] d, input bit e, input int c);
        exp_t x;
        x.ch = ch; x.is_rd = rd; x.rdata = d; x.err = e; x.cyc = c;
        return x;
    endfunction

    task automatic check_ack(input string tag, input exp_t e, input logic [N-1:0] ack,
                             input logic [DW-1:0] rd, input logic er);
        chk({tag, "_ack"}, 32'(ack), 32'(1 << e.ch));
        chk({tag, "_ack_cycle"}, 32'(cyc), 32'(e.cyc));
        if (e.is_rd) chk({tag, "_rdata"}, 32'(rd), 32'(e.rdata));
        chk({tag, "_err"}, 32'(er), 32'(e.err));
    endtask

    // Monitors: pop an expectation whenever an ack appears.
    always @(negedge clk) begin
        if (!reset && ack_a !== '0) begin
            if (q_a.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_ack_a actual=%b expected=none", ack_a);
            end else check_ack("a", q_a.pop_front(), ack_a, rdata_a, err_a);
        end
    end

    always @(negedge clk) begin
        if (!reset && ack_b !== '0) begin
            if (q_b.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_ack_b actual=%b expected=none", ack_b);
            end else check_ack("b", q_b.pop_front(), ack_b, rdata_b, err_b);
        end
    end

    logic [DW-1:0] fair_data [0:3];

    initial begin
        int c0;
        req_a = '0; wr_a = '0; addr_a = '0; wdata_a = '0;
        req_b = '0; wr_b = '0; addr_b = '0; wdata_b = '0;
        fair_data[0] = 12'h5A5; fair_data[1] = 12'h3C7;
        fair_data[2] = 12'h111; fair_data[3] = 12'h222;
        reset = 1'b1;
        repeat (3) tick;

        // reset state
        chk("rst_ack", 32'(ack_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_wren", 32'(mem_wren_a), 0);
        chk("rst_addr", 32'(mem_address_a), 0);
        chk("rst_data", 32'(mem_data_a), 0);
        chk("rst_rdata", 32'(rdata_a), 0);
        chk("rst_err", 32'(err_a), 0);

        // core 2 read of 0A5
        reset = 1'b0;
        req_a = 4'b0100; wr_a = '0; addr_a[2*AW +: AW] = 12'h0A5;
        c0 = cyc; q_a.push_back(mk(2, 1, 12'h3C7, 0, c0 + 3));
        tick;
        chk("t1_addr", 32'(mem_address_a), 32'h0A5);
        chk("t1_busy", 32'(busy_a), 1);
        chk("t1_wren", 32'(mem_wren_a), 0);
        tick; tick;
        req_a = '0;
        tick;
        chk("t1_idle", 32'(busy_a), 0);

        // core 1 write 5A5 to 100
        req_a = 4'b0010; wr_a = 4'b0010; addr_a[AW +: AW] = 12'h100; wdata_a[DW +: DW] = 12'h5A5;
        c0 = cyc; q_a.push_back(mk(1, 0, 12'h000, 0, c0 + 3));
        tick;
        chk("t2_wren", 32'(mem_wren_a), 1);
        chk("t2_data", 32'(mem_data_a), 32'h5A5);
        chk("t2_addr", 32'(mem_address_a), 32'h100);
        tick;
        chk("t2_wren_wait", 32'(mem_wren_a), 0);
        tick;
        chk("t2_wren_ack", 32'(mem_wren_a), 0);
        chk("t2_rdata_hold", 32'(rdata_a), 32'h3C7);
        req_a = '0; wr_a = '0;
        tick;
        // core 0 reads it back
        req_a = 4'b0001; addr_a[0 +: AW] = 12'h100;
        c0 = cyc; q_a.push_back(mk(0, 1, 12'h5A5, 0, c0 + 3));
        repeat (3) tick;
        req_a = '0;
        tick;

        // all requests after reset: 0,1,2,3,0 every 4 cycles
        reset = 1'b1;
        tick;
        reset = 1'b0;
        addr_a[0*AW +: AW] = 12'h100; addr_a[1*AW +: AW] = 12'h0A5;
        addr_a[2*AW +: AW] = 12'h200; addr_a[3*AW +: AW] = 12'h201;
        req_a = 4'hF; wr_a = '0;
        c0 = cyc;
        for (int k = 0; k < 5; k++) q_a.push_back(mk(k % 4, 1, fair_data[k % 4], 0, c0 + 3 + 4*k));
        repeat (19) tick;
        req_a = '0;
        tick;
        chk("t3_idle", 32'(busy_a), 0);

        // reset during WAIT of a core 3 read aborts it
        req_a = 4'b1000;
        tick; tick;
        reset = 1'b1;
        tick;
        chk("t4_busy", 32'(busy_a), 0);
        chk("t4_wren", 32'(mem_wren_a), 0);
        chk("t4_ack", 32'(ack_a), 0);
        reset = 1'b0;
        req_a = 4'hF;
        c0 = cyc; q_a.push_back(mk(0, 1, 12'h5A5, 0, c0 + 3));
        repeat (3) tick;
        req_a = '0;
        tick;
        chk("t4_idle", 32'(busy_a), 0);

        // write to the protected region
        req_a = 4'b0010; wr_a = 4'b0010; addr_a[AW +: AW] = 12'h020; wdata_a[DW +: DW] = 12'hABC;
        c0 = cyc; q_a.push_back(mk(1, 0, 12'h000, PROT, c0 + 3));
        tick;
        chk("t5_wren", 32'(mem_wren_a), 32'(!PROT));
        tick; tick;
        req_a = '0; wr_a = '0;
        tick;
        chk("t5_mem", 32'(mem_a[12'h020]), PROT ? 32'h000 : 32'hABC);
        // write just above the region
        req_a = 4'b0010; wr_a = 4'b0010; addr_a[AW +: AW] = 12'h040; wdata_a[DW +: DW] = 12'h123;
        c0 = cyc; q_a.push_back(mk(1, 0, 12'h000, 0, c0 + 3));
        tick;
        chk("t5_wren_ok", 32'(mem_wren_a), 1);
        tick; tick;
        req_a = '0; wr_a = '0;
        tick;
        chk("t5_mem_ok", 32'(mem_a[12'h040]), 32'h123);
        // protected region is readable
        req_a = 4'b0100; addr_a[2*AW +: AW] = 12'h020;
        c0 = cyc; q_a.push_back(mk(2, 1, PROT ? 12'h000 : 12'hABC, 0, c0 + 3));
        repeat (3) tick;
        req_a = '0;
        tick;

        // latency 3: core 0 read, req dropped in cycle 2
        req_b = 4'b0001; wr_b = '0; addr_b[0 +: AW] = 12'h010;
        c0 = cyc; q_b.push_back(mk(0, 1, 12'h7FF, 0, c0 + 5));
        tick; tick;
        chk("t6_busy", 32'(busy_b), 1);
        req_b = '0;
        repeat (3) tick;
        tick;
        chk("t6_idle", 32'(busy_b), 0);

        repeat (2) tick;
        chk("pending_a", 32'(q_a.size()), 0);
        chk("pending_b", 32'(q_b.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/shared_mem_arbiter.md
Name: shared_mem_arbiter

Overview:
- Round-robin arbiter that lets core_count accumulator cores share one single-port synchronous data memory. It generalises the single-core memory path (AR/DR to MemoryQ) to N channels.
- Sits between the per-core AR/DR/mem_read/mem_write signals and the shared memory.
- Serialises accesses and returns a one-cycle ack per completed transaction.

Parameters:
- core_count, 4, number of requesting cores (2..16).
- reg_width, 12, data word width.
- addr_width, 12, memory address width.
- mem_latency, 1, memory read latency in cycles from the address edge to valid q (1..4).
- protect_limit, 12'd64, upper bound (exclusive) of the write-protected region; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  core_count  per-core request; held high until ack.
- wr  in  core_count  per-core direction: 1 = write, 0 = read; sampled at grant.
- addr  in  core_count*addr_width  flattened addresses; core i occupies bits [i*addr_width +: addr_width].
- wdata  in  core_count*reg_width  flattened write data, same packing as addr.
- ack  out  core_count  one-hot, one-cycle completion pulse.
- rdata  out  reg_width  read data, valid in the ack cycle of a read.
- err  out  1  protection violation flag, valid in the ack cycle.
- busy  out  1  high whenever the FSM is not IDLE.
- mem_address  out  addr_width  to memory address.
- mem_data  out  reg_width  to memory data.
- mem_wren  out  1  to memory write enable.
- mem_q  in  reg_width  from memory read data.

Behaviour:
- Reset (synchronous, active-high; takes effect on the next clk edge):
  - FSM goes to IDLE.
  - ack=0, err=0, busy=0, mem_wren=0.
  - mem_address=0, mem_data=0, rdata=0.
  - Round-robin pointer last=core_count-1, so core 0 has first priority.
- FSM states are IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If any req bit is high, select the first requester scanning last+1, last+2, ..., wrapping modulo core_count.
  - Latch the channel index, wr bit, address and wdata into mem_address/mem_data. Set mem_wren = wr.
  - Go to ISSUE. With no requests, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - Memory outputs are stable. mem_wren is high only in this state.
  - Next state is WAIT, with counter = mem_latency.
- WAIT:
  - mem_wren=0. Decrement the counter each cycle.
  - When the counter reaches 1: for a read, capture mem_q into rdata. Then go to ACK.
- ACK (1 cycle):
  - ack[ch]=1, all other ack bits 0. Set last=ch.
  - rdata holds the captured value and does not change on writes.
  - Next state is IDLE. The following grant can occur in the IDLE cycle immediately after.
- Latency: req high in IDLE cycle 0 gives ISSUE in cycle 1, WAIT in cycles 2..1+mem_latency, and ack in cycle 2+mem_latency. With mem_latency=1 the ack is in cycle 3. Throughput is one transaction per 3+mem_latency cycles.
- rdata, mem_address and mem_data hold their last value between transactions.
- Fairness: a core that was just served has lowest priority on the next arbitration. With all req bits high, grants go 0, 1, 2, 3, 0, ...
- Requests arriving while busy are not lost; they are considered at the next IDLE.
- If req drops mid-transaction, the transaction still completes and ack still pulses. A change of wr/addr/wdata after grant has no effect.
- A core that holds req high in its own ack cycle is re-arbitrated normally in the next IDLE and receives no special priority.
- Reset during ISSUE/WAIT/ACK aborts the transaction: no ack is issued, mem_wren=0 from the next edge, and the pointer is restored to its reset value.
- A single requester is always granted, regardless of the pointer.

Optional Feature:
- Macro: SHARED_MEM_WR_PROTECT_EN.
- Defined:
  - A write with latched address < protect_limit is suppressed: mem_wren stays 0 in ISSUE.
  - The transaction still runs the full state sequence. err=1 in its ACK cycle.
  - Reads of the protected region are allowed, with err=0.
- Undefined:
  - protect_limit is ignored, all writes reach memory, and err is constant 0.

Test Plan:
- Read from core 2, mem_latency=1, memory preloaded addr 12'h0A5 = 12'h3C7: req=4'b0100, wr=0 at cycle 0 -> mem_address=12'h0A5 in cycle 1, ack=4'b0100 and rdata=12'h3C7 in cycle 3, busy low in cycle 4.
- Write from core 1 with addr=12'h100, wdata=12'h5A5 -> mem_wren high only in cycle 1 with mem_data=12'h5A5. A later core-0 read of 12'h100 returns 12'h5A5.
- All four req held high after reset -> ack order is cores 0, 1, 2, 3, 0, with acks spaced 4 cycles apart at mem_latency=1.
- Reset asserted during WAIT of a core-3 read -> no ack, busy=0 after the edge. Next all-request grant goes to core 0.
- mem_latency=3, core 0 read of addr 12'h010 holding 12'h7FF -> ack in cycle 5 with rdata=12'h7FF. Core 0 drops req in cycle 2 and still receives the ack.
- With SHARED_MEM_WR_PROTECT_EN, core 1 writes 12'hABC to addr 12'h020 -> mem_wren stays 0, ack with err=1, memory unchanged. A write to 12'h040 succeeds with err=0. Without the macro, the write to 12'h020 succeeds with err=0.
